// File: rtl/bin2bcd_number_module.sv
// bin2bcd_number_module: sequential double-dabble binary-to-packed-BCD converter with start/done handshake.
// Results saturate at 999999. Number_Sig only changes when a conversion completes.
module bin2bcd_number_module #(
    parameter int BIN_WIDTH = 20
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 Start_Sig,
    input  logic [BIN_WIDTH-1:0] Bin_Data,
    output logic [23:0]          Number_Sig,
    output logic                 Done_Sig,
    output logic                 Busy_Sig,
    output logic                 Over_Flag
);
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
    localparam logic [4:0] LAST = 5'(BIN_WIDTH - 1);

    state_t               state, state_nxt;
    logic [BIN_WIDTH-1:0] bin;
    logic [23:0]          bcd, bcd_adj;
    logic [4:0]           cnt;
    logic                 ovr;

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) state <= IDLE;
        else       state <= state_nxt;

    always_comb
        state_nxt = (state == IDLE)  ? (Start_Sig ? SHIFT : IDLE) :
                    (state == SHIFT) ? (cnt == LAST ? FINISH : SHIFT) : IDLE;

    always_comb
        Busy_Sig = (state != IDLE);

    // Each nibble is adjusted on its own; carries between digits come from the shift.
    for (genvar g = 0; g < 6; g++) begin : g_adj
        assign bcd_adj[4*g +: 4] = (bcd[4*g +: 4] >= 4'd5) ? bcd[4*g +: 4] + 4'd3 : bcd[4*g +: 4];
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bin        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            ovr        <= 1'b0;
            Number_Sig <= '0;
            Done_Sig   <= 1'b0;
            Over_Flag  <= 1'b0;
        end else begin
            Done_Sig <= (state == FINISH);
            if (state == IDLE && Start_Sig) begin
                bin <= Bin_Data;
                bcd <= '0;
                cnt <= '0;
                ovr <= 32'(Bin_Data) > 32'd999999;
            end else if (state == SHIFT) begin
                {bcd, bin} <= {bcd_adj[22:0], bin, 1'b0};
                cnt        <= cnt + 5'd1;
            end else if (state == FINISH) begin
                Number_Sig <= ovr ? 24'h999999 : bcd;
                Over_Flag  <= ovr;
            end
        end
    end
endmodule

// File: doc/bin2bcd_number_module.md
Name: bin2bcd_number_module

Overview:
- Sequential binary-to-BCD converter (shift-add-3 / double dabble) for the 6-digit seven-segment display path.
- Sits directly upstream of smg_interface: consumes an unsigned binary count from application logic and produces the 24-bit packed-BCD Number_Sig that smg_interface scans out.
- Handshake: start pulse in, done pulse out.
- Number_Sig changes only on completed conversions, so the display never shows intermediate values.

Parameters:
- BIN_WIDTH, 20, width of the binary input. Legal range 4..20. 20 bits covers 0..1048575.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RSTn  input  1  reset, asynchronous assert, active-low.
- Start_Sig  input  1  request a conversion of Bin_Data; sampled only while Busy_Sig=0.
- Bin_Data  input  BIN_WIDTH  unsigned binary value; sampled on the accepting Start_Sig edge only.
- Number_Sig  output  24  packed BCD result to smg_interface: [23:20] hundred-thousands ... [3:0] units.
- Done_Sig  output  1  one-cycle pulse when Number_Sig has just been updated.
- Busy_Sig  output  1  high while a conversion is in progress.
- Over_Flag  output  1  last completed conversion saturated (input > 999999).

Behaviour:
- Reset (RSTn=0, asynchronous) puts the block in IDLE and drives these values:
  - Number_Sig=24'h000000
  - Done_Sig=0
  - Busy_Sig=0
  - Over_Flag=0
  - Internal shift register and counter are cleared.
- Reset mid-conversion aborts the conversion. No Done_Sig is produced. Number_Sig reads 0.
- State machine, registered: IDLE -> SHIFT -> FINISH -> IDLE.
- IDLE:
  - Busy_Sig=0.
  - On an edge with Start_Sig=1, latch Bin_Data into the binary shift register and clear the 24-bit BCD accumulator.
  - Clear the iteration counter and set the overrange bit to (Bin_Data > 999999).
  - Then Busy_Sig=1 and go to SHIFT.
- SHIFT:
  - Exactly BIN_WIDTH cycles.
  - Each cycle, every BCD nibble that is >= 5 gets +3 (4-bit add, no carry between nibbles).
  - The combined {BCD, binary} register then shifts left by 1, with the binary MSB entering BCD bit 0.
  - After the BIN_WIDTH-th shift, go to FINISH.
- FINISH (one cycle):
  - Number_Sig <= overrange ? 24'h999999 : BCD accumulator.
  - Over_Flag <= overrange.
  - Done_Sig=1 for this cycle only.
  - Busy_Sig returns to 0 on the same edge that raises Done_Sig. Next state IDLE.
- Latency:
  - Start accepted at edge k; Busy_Sig=1 after edge k.
  - Shifts occur on edges k+1..k+BIN_WIDTH.
  - Number_Sig, Done_Sig and Over_Flag update at edge k+BIN_WIDTH+1 (21 cycles for the default).
- Throughput: a new Start_Sig is accepted on the cycle Done_Sig is high, because state is IDLE then. So back-to-back conversions take one every BIN_WIDTH+2 cycles.
- Start_Sig while Busy_Sig=1 is ignored: not queued, and the latched operand is unchanged.
- Start_Sig held high is treated as a new request each time the FSM is in IDLE.
- Number_Sig and Over_Flag hold their previous values throughout SHIFT.
- Bin_Data may change freely after the accepting edge.
- For BIN_WIDTH < 20, overrange can never occur and Over_Flag stays 0. Upper BCD nibbles result as 0.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset: assert RSTn=0 asynchronously mid-cycle -> all outputs 0 immediately. Release, idle 5 cycles -> outputs unchanged.
- Start_Sig=1 for one cycle with Bin_Data=123456 -> Busy_Sig high for 21 cycles. Done_Sig pulses once 21 edges after the accepting edge. Number_Sig=24'h123456, Over_Flag=0.
- Boundary values, each with Over_Flag checked:
  - 0 -> 24'h000000
  - 9 -> 24'h000009
  - 10 -> 24'h000010
  - 999999 -> 24'h999999, Over_Flag=0
  - 1000000 -> 24'h999999, Over_Flag=1
  - 1048575 -> 24'h999999, Over_Flag=1
- Start 000042, then pulse Start with 777777 five cycles later (busy) -> second start ignored; result 24'h000042, single Done_Sig. Start asserted on the Done cycle with 000777 -> accepted; result 24'h000777 22 cycles after the first Done.
- Convert 654321, then assert RSTn=0 at SHIFT cycle 10 and release -> no Done_Sig; Number_Sig=0, Busy_Sig=0. A new conversion of 000100 -> 24'h000100.
- Convert 500000, then Start 1 -> Number_Sig holds 24'h500000 for every cycle until the second Done, then 24'h000001.
